// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: EX redirect, instruction-memory request/response, and the ID-side buffer port.
interface if_fetch_unit_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_ready_i;

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
        output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
        input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests into a small slot
// ring, and drops responses belonging to fetches made stale by a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    if_fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    function automatic cnt_t b2c(input logic b);
        return {{(CW-1){1'b0}}, b};
    endfunction

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_slot_pc   [DEPTH];
    logic [31:0]      r_slot_inst [DEPTH];
    logic [DEPTH-1:0] r_filled;
    ptr_t             r_alloc_ptr, r_fill_ptr, r_pop_ptr;
    cnt_t             r_alloc_cnt, r_pend_cnt, r_drop_cnt;

    cnt_t w_used;
    logic w_req, w_grant, w_dropping, w_fill, w_valid, w_pop;
    cnt_t w_redir_drop;

    // Stale-fetch drops occupy slots until their responses come back.
    assign w_used       = r_alloc_cnt + r_drop_cnt;
    assign w_req        = rst_n & (w_used < DEPTH_C) & ~bus.redirect_i;
    assign w_grant      = w_req & bus.imem_gnt_i;
    assign w_dropping   = bus.imem_rvalid_i & (r_drop_cnt != '0);
    assign w_fill       = bus.imem_rvalid_i & (r_drop_cnt == '0) & (r_pend_cnt != '0);
    assign w_valid      = r_filled[r_pop_ptr];
    assign w_pop        = w_valid & bus.if_ready_i;
    // Any response consumed in the redirect cycle is gone, whichever counter it belonged to.
    assign w_redir_drop = r_drop_cnt + r_pend_cnt - b2c(w_dropping | w_fill);

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = r_fetch_pc;
    assign bus.if_valid_o  = w_valid;
    assign bus.if_pc_o     = w_valid ? r_slot_pc[r_pop_ptr]   : 32'h0;
    assign bus.if_inst_o   = w_valid ? r_slot_inst[r_pop_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_alloc_cnt <= '0;
            r_pend_cnt  <= '0;
            r_drop_cnt  <= '0;
        end else if (bus.redirect_i) begin
            r_fetch_pc  <= bus.redirect_pc_i & ~32'h3;
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_alloc_cnt <= '0;
            r_pend_cnt  <= '0;
            r_drop_cnt  <= w_redir_drop;
        end else begin
            if (w_grant) begin
                r_fetch_pc  <= r_fetch_pc + 32'd4;
                r_alloc_ptr <= r_alloc_ptr + ptr_t'(1);
            end
            if (w_fill) r_fill_ptr <= r_fill_ptr + ptr_t'(1);
            if (w_pop)  r_pop_ptr  <= r_pop_ptr + ptr_t'(1);
            if (w_dropping) r_drop_cnt <= r_drop_cnt - cnt_t'(1);
            r_alloc_cnt <= r_alloc_cnt + b2c(w_grant) - b2c(w_pop);
            r_pend_cnt  <= r_pend_cnt + b2c(w_grant) - b2c(w_fill);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_fill && r_fill_ptr == ptr_t'(i))
                    r_filled[i] <= 1'b1;
                else if (w_pop && r_pop_ptr == ptr_t'(i))
                    r_filled[i] <= 1'b0;
            end
        end
    end

    // Slot payload carries no reset; visibility is governed by r_filled alone.
    always_ff @(posedge clk) begin
        if (w_grant) r_slot_pc[r_alloc_ptr]  <= r_fetch_pc;
        if (w_fill)  r_slot_inst[r_fill_ptr] <= bus.imem_rdata_i;
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model, grant-order scoreboard, per-cycle vector table
// and hand-written redirect / stall / wrap / reset sequences.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clk;
    logic rst_n;
    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        logic gnt; logic ready;
        logic exp_req; logic [31:0] exp_addr; logic exp_valid; logic [31:0] exp_pc;
    } vec_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fpc;
    int n_checks = 0, n_pass = 0, n_grant = 0, n_pop = 0;
    int cyc = 0, lat = 1, last_due = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus.redirect_i = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        while (!bus.if_valid_o && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_valid"}, {31'b0, bus.if_valid_o}, 32'd1);
    endtask

    // Memory: in-order responses, one per cycle, each no earlier than its due cycle.
    initial begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = $urandom;
            end
        end
    end

    // Scoreboard: grants push expected words, pops compare, redirect/reset discard everything.
    initial begin
        exp_fpc = RESET_PC;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mem_q.delete();
                exp_fpc  = RESET_PC;
                last_due = 0;
            end else begin
                if (bus.imem_req_o && bus.imem_gnt_i) begin
                    int due;
                    n_grant++;
                    chk("grant_addr", bus.imem_addr_o, exp_fpc);
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back('{addr: bus.imem_addr_o, due: due});
                    exp_q.push_back(bus.imem_addr_o);
                    exp_fpc = exp_fpc + 32'd4;
                end
                if (bus.redirect_i) begin
                    chk("redirect_req_low", {31'b0, bus.imem_req_o}, 32'd0);
                    exp_q.delete();
                    exp_fpc = bus.redirect_pc_i & ~32'h3;
                end else if (bus.if_valid_o && bus.if_ready_i) begin
                    logic [31:0] epc;
                    n_pop++;
                    chk("pop_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        epc = exp_q.pop_front();
                        chk("pop_pc", bus.if_pc_o, epc);
                        chk("pop_inst", bus.if_inst_o, mem_word(epc));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    vec_t vecs[7];

    initial begin
        int p0, g0;
        // Straight-line fetch from reset, gnt=1, latency 1, ready=1.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        rst_n = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.imem_gnt_i    = 1'b1;
        bus.if_ready_i    = 1'b1;
        lat = 1;
        tick();
        chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        tick();
        chk("rst_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("rst_pc", bus.if_pc_o, 32'h0);
        chk("rst_inst", bus.if_inst_o, 32'h0);
        chk("rst_addr", bus.imem_addr_o, RESET_PC);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bus.imem_gnt_i = vecs[i].gnt;
            bus.if_ready_i = vecs[i].ready;
            #1;
            chk($sformatf("vec%0d_req", i), {31'b0, bus.imem_req_o}, {31'b0, vecs[i].exp_req});
            chk($sformatf("vec%0d_addr", i), bus.imem_addr_o, vecs[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, bus.if_valid_o}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_pc", i), bus.if_pc_o, vecs[i].exp_pc);
            tick();
        end

        // ID stall: exactly DEPTH grants, then requests stop; nothing lost on release.
        do_reset();
        bus.imem_gnt_i = 1'b1;
        bus.if_ready_i = 1'b0;
        lat = 1;
        g0 = n_grant;
        repeat (6) tick();
        chk("stall_grants", n_grant - g0, DEPTH);
        #1;
        chk("stall_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("stall_hold_pc", bus.if_pc_o, RESET_PC);
        p0 = n_pop;
        bus.if_ready_i = 1'b1;
        repeat (12) tick();
        chk("stall_release_pops", {31'b0, (n_pop - p0) >= 4}, 32'd1);

        // Redirect with two fetches in flight: both stale responses dropped.
        do_reset();
        lat = 3;
        bus.imem_gnt_i = 1'b1;
        bus.if_ready_i = 1'b1;
        tick();
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0102;
        #1;
        chk("redir2_req", {31'b0, bus.imem_req_o}, 32'd0);
        tick();
        bus.redirect_i = 1'b0;
        #1;
        chk("redir2_addr", bus.imem_addr_o, 32'h0000_0100);
        chk("redir2_blocked", {31'b0, bus.imem_req_o}, 32'd0);
        wait_valid(20, "redir2");
        chk("redir2_first_pc", bus.if_pc_o, 32'h0000_0100);
        chk("redir2_first_inst", bus.if_inst_o, mem_word(32'h0000_0100));

        // Redirect in the same cycle as an rvalid, with gnt held high.
        do_reset();
        lat = 2;
        bus.imem_gnt_i = 1'b1;
        bus.if_ready_i = 1'b1;
        tick();
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0200;
        #1;
        chk("redir_rv_rvalid_present", {31'b0, bus.imem_rvalid_i}, 32'd1);
        chk("redir_rv_req", {31'b0, bus.imem_req_o}, 32'd0);
        tick();
        bus.redirect_i = 1'b0;
        #1;
        chk("redir_rv_addr", bus.imem_addr_o, 32'h0000_0200);
        chk("redir_rv_req_after", {31'b0, bus.imem_req_o}, 32'd1);
        wait_valid(20, "redir_rv");
        chk("redir_rv_first_pc", bus.if_pc_o, 32'h0000_0200);
        chk("redir_rv_first_inst", bus.if_inst_o, mem_word(32'h0000_0200));

        // Fetch PC wraps from the top of the address space to zero.
        do_reset();
        lat = 1;
        bus.imem_gnt_i = 1'b0;
        bus.if_ready_i = 1'b1;
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        bus.redirect_i = 1'b0;
        #1;
        chk("wrap_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
        bus.imem_gnt_i = 1'b1;
        tick();
        chk("wrap_addr_zero", bus.imem_addr_o, 32'h0000_0000);
        wait_valid(10, "wrap");
        chk("wrap_first_pc", bus.if_pc_o, 32'hFFFF_FFFC);

        // One-cycle reset in the middle of a stream.
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_req_low", {31'b0, bus.imem_req_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("midrst_pc", bus.if_pc_o, 32'h0);
        chk("midrst_inst", bus.if_inst_o, 32'h0);
        chk("midrst_addr", bus.imem_addr_o, RESET_PC);
        #1;
        chk("midrst_req_restart", {31'b0, bus.imem_req_o}, 32'd1);
        repeat (6) tick();

        // Random traffic: grant gaps, ID stalls, varying latency, occasional redirects.
        for (int i = 0; i < 400; i++) begin
            bus.imem_gnt_i    = ($urandom_range(0, 3) != 0);
            bus.if_ready_i    = ($urandom_range(0, 3) != 0);
            lat               = $urandom_range(1, 3);
            bus.redirect_i    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc_i = $urandom;
            tick();
        end

        bus.redirect_i = 1'b0;
        bus.imem_gnt_i = 1'b0;
        bus.if_ready_i = 1'b1;
        repeat (20) tick();
        chk("drain_scoreboard", exp_q.size(), 32'd0);
        chk("drain_memory", mem_q.size(), 32'd0);
        chk("drain_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("random_pops_seen", {31'b0, n_pop > 60}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
